// File: rtl/alu_pkg.sv
// Shared ALU widths, opcode encodings, wait-window length and operand-need decoder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a. ALU_TIMEOUT_EN (see alu_wait_ctrl) selects the late-operand wait window.
package alu_pkg;

    localparam int ALU_W       = 8;
    localparam int ALU_N       = 4;
    localparam int ALU_TIMEOUT = 16;
    localparam int ALU_CNT_W   = $clog2(ALU_TIMEOUT);

    typedef enum logic [3:0] {
        A_ADD     = 4'd0,
        A_SUB     = 4'd1,
        A_ADD_CIN = 4'd2,
        A_SUB_CIN = 4'd3,
        A_INC_A   = 4'd4,
        A_DEC_A   = 4'd5,
        A_INC_B   = 4'd6,
        A_DEC_B   = 4'd7,
        A_CMP     = 4'd8
    } arith_op_e;

    typedef enum logic [3:0] {
        L_AND     = 4'd0,
        L_NAND    = 4'd1,
        L_OR      = 4'd2,
        L_NOR     = 4'd3,
        L_XOR     = 4'd4,
        L_XNOR    = 4'd5,
        L_NOT_A   = 4'd6,
        L_NOT_B   = 4'd7,
        L_SHR1_A  = 4'd8,
        L_SHL1_A  = 4'd9,
        L_SHR1_B  = 4'd10,
        L_SHL1_B  = 4'd11,
        L_ROL_A_B = 4'd12,
        L_ROR_A_B = 4'd13
    } logic_op_e;

    // Operands an opcode consumes: 01 = A only, 10 = B only, 11 = both, 00 = illegal opcode.
    function automatic logic [1:0] op_need(input logic mode, input logic [3:0] cmd, input logic cmd_hi);
        logic [1:0] need;
        need = 2'b00;
        if (!cmd_hi) begin
            if (mode) begin
                case (cmd)
                    A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: need = 2'b11;
                    A_INC_A, A_DEC_A:                          need = 2'b01;
                    A_INC_B, A_DEC_B:                          need = 2'b10;
                    default:                                   need = 2'b00;
                endcase
            end else begin
                case (cmd)
                    L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR,
                    L_ROL_A_B, L_ROR_A_B:                      need = 2'b11;
                    L_NOT_A, L_SHR1_A, L_SHL1_A:               need = 2'b01;
                    L_NOT_B, L_SHR1_B, L_SHL1_B:               need = 2'b10;
                    default:                                   need = 2'b00;
                endcase
            end
        end
        return need;
    endfunction

endpackage

// File: rtl/alu_wait_ctrl.sv
// IDLE/WAIT control for a two-operand op that arrives with only one operand valid; presents the effective operation to the datapath.
// Latency: 0 (combinational select); the late operand completes on the edge it arrives, timeout fires on the 16th WAIT edge.
// Backpressure: CE=0 freezes state/counter; ALU_TIMEOUT_EN undefined -> pure pass-through, no WAIT state.
module alu_wait_ctrl
    import alu_pkg::*;
#(
    parameter int W = ALU_W,
    parameter int N = ALU_N
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_ce,
    input  logic [1:0]   i_need,
    input  logic [W-1:0] i_opa,
    input  logic [W-1:0] i_opb,
    input  logic         i_cin,
    input  logic         i_mode,
    input  logic [1:0]   i_valid,
    input  logic [N-1:0] i_cmd,
    output logic [W-1:0] o_opa,
    output logic [W-1:0] o_opb,
    output logic         o_cin,
    output logic         o_mode,
    output logic [1:0]   o_valid,
    output logic [N-1:0] o_cmd,
    output logic         o_fire,
    output logic         o_timeout
);

`ifdef ALU_TIMEOUT_EN
    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e               r_state;
    logic [ALU_CNT_W-1:0] r_cnt;
    logic [W-1:0]         r_opa;
    logic [W-1:0]         r_opb;
    logic                 r_cin;
    logic                 r_mode;
    logic [N-1:0]         r_cmd;
    logic [1:0]           r_have;

    logic w_start;
    logic w_arrive;
    logic w_expire;

    assign w_start  = (r_state == S_IDLE) && (i_need == 2'b11) &&
                      ((i_valid == 2'b01) || (i_valid == 2'b10));
    assign w_arrive = (r_state == S_WAIT) && ((i_valid & ~r_have) != 2'b00);
    assign w_expire = (r_state == S_WAIT) && !w_arrive &&
                      (r_cnt == ALU_CNT_W'(ALU_TIMEOUT - 1));

    // Wait FSM: latch the partial op, count CE edges, leave on arrival or expiry.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_cin   <= 1'b0;
            r_mode  <= 1'b0;
            r_cmd   <= '0;
            r_have  <= 2'b00;
        end else if (i_ce) begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                        r_opa   <= i_opa;
                        r_opb   <= i_opb;
                        r_cin   <= i_cin;
                        r_mode  <= i_mode;
                        r_cmd   <= i_cmd;
                        r_have  <= i_valid;
                    end
                end
                S_WAIT: begin
                    if (w_arrive || w_expire) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Effective op: live inputs in IDLE, latched op plus the newly arrived operand in WAIT.
    always_comb begin
        o_opa     = i_opa;
        o_opb     = i_opb;
        o_cin     = i_cin;
        o_mode    = i_mode;
        o_valid   = i_valid;
        o_cmd     = i_cmd;
        o_fire    = !w_start;
        o_timeout = 1'b0;
        if (r_state == S_WAIT) begin
            o_opa     = r_have[0] ? r_opa : i_opa;
            o_opb     = r_have[1] ? r_opb : i_opb;
            o_cin     = r_cin;
            o_mode    = r_mode;
            o_valid   = 2'b11;
            o_cmd     = r_cmd;
            o_fire    = w_arrive || w_expire;
            o_timeout = w_expire;
        end
    end
`else
    logic w_unused;

    // No wait window: every accepted op completes immediately with whatever operands are valid.
    always_comb begin
        o_opa     = i_opa;
        o_opb     = i_opb;
        o_cin     = i_cin;
        o_mode    = i_mode;
        o_valid   = i_valid;
        o_cmd     = i_cmd;
        o_fire    = 1'b1;
        o_timeout = 1'b0;
    end

    assign w_unused = ^{clk, i_rst_n, i_ce, i_need};
`endif

endmodule

// File: rtl/modport_alu.sv
// Registered W-bit ALU: arithmetic/logical commands, unsigned compare flags, operand-valid checks, optional late-operand window (ALU_TIMEOUT_EN).
// Latency: 1 cycle from the CE=1 edge that completes an op; outputs hold until the next completed op.
// Backpressure: CE=0 freezes all state and outputs; no ready signal, a new CMD during WAIT is ignored.
module modport_alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W,
    parameter int N = ALU_N
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         CE,
    input  logic [W-1:0] OPA,
    input  logic [W-1:0] OPB,
    input  logic         Cin,
    input  logic         mode,
    input  logic [1:0]   inp_valid,
    input  logic [N-1:0] CMD,
    output logic [W:0]   RES,
    output logic         OFLOW,
    output logic         COUT,
    output logic         G,
    output logic         L,
    output logic         E,
    output logic         ERR
);

    localparam int SW = $clog2(W);

    logic [1:0]   w_need_in;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic         w_cin;
    logic         w_mode;
    logic [1:0]   w_valid;
    logic [N-1:0] w_cmd;
    logic         w_fire;
    logic         w_timeout;
    logic [1:0]   w_need;
    logic [W:0]   w_ax;
    logic [W:0]   w_bx;
    logic [W:0]   w_cinx;
    logic [SW-1:0] w_amt;
    logic         w_rot_hi;
    logic [W-1:0] w_rol;
    logic [W-1:0] w_ror;

    logic [W:0]   w_res;
    logic         w_oflow;
    logic         w_cout;
    logic         w_g;
    logic         w_l;
    logic         w_e;
    logic         w_err;

    logic [W:0]   r_res;
    logic         r_oflow;
    logic         r_cout;
    logic         r_g;
    logic         r_l;
    logic         r_e;
    logic         r_err;

    assign w_need_in = op_need(mode, CMD[3:0], |(CMD >> 4));

    alu_wait_ctrl #(.W(W), .N(N)) u_wait_ctrl (
        .clk       (clk),
        .i_rst_n   (RST),
        .i_ce      (CE),
        .i_need    (w_need_in),
        .i_opa     (OPA),
        .i_opb     (OPB),
        .i_cin     (Cin),
        .i_mode    (mode),
        .i_valid   (inp_valid),
        .i_cmd     (CMD),
        .o_opa     (w_a),
        .o_opb     (w_b),
        .o_cin     (w_cin),
        .o_mode    (w_mode),
        .o_valid   (w_valid),
        .o_cmd     (w_cmd),
        .o_fire    (w_fire),
        .o_timeout (w_timeout)
    );

    assign w_need   = op_need(w_mode, w_cmd[3:0], |(w_cmd >> 4));
    assign w_ax     = {1'b0, w_a};
    assign w_bx     = {1'b0, w_b};
    assign w_cinx   = {{W{1'b0}}, w_cin};
    assign w_amt    = w_b[SW-1:0];
    assign w_rot_hi = |(w_b >> SW);
    assign w_rol    = (w_a << w_amt) | (w_a >> (W - int'(w_amt)));
    assign w_ror    = (w_a >> w_amt) | (w_a << (W - int'(w_amt)));

    // Datapath: one result per op; flags an op does not define stay 0, any error zeroes RES except rotate range errors.
    always_comb begin
        w_res   = '0;
        w_oflow = 1'b0;
        w_cout  = 1'b0;
        w_g     = 1'b0;
        w_l     = 1'b0;
        w_e     = 1'b0;
        w_err   = 1'b0;
        if (w_timeout || (w_need == 2'b00) || ((w_need & ~w_valid) != 2'b00)) begin
            w_err = 1'b1;
        end else if (w_mode) begin
            case (w_cmd[3:0])
                A_ADD:     begin w_res = w_ax + w_bx;          w_cout  = w_res[W]; end
                A_ADD_CIN: begin w_res = w_ax + w_bx + w_cinx; w_cout  = w_res[W]; end
                A_INC_A:   begin w_res = w_ax + 1'b1;          w_cout  = w_res[W]; end
                A_INC_B:   begin w_res = w_bx + 1'b1;          w_cout  = w_res[W]; end
                A_SUB:     begin w_res = w_ax - w_bx;          w_oflow = w_res[W]; end
                A_SUB_CIN: begin w_res = w_ax - w_bx - w_cinx; w_oflow = w_res[W]; end
                A_DEC_A:   begin w_res = w_ax - 1'b1;          w_oflow = w_res[W]; end
                A_DEC_B:   begin w_res = w_bx - 1'b1;          w_oflow = w_res[W]; end
                A_CMP: begin
                    w_g = (w_a > w_b);
                    w_l = (w_a < w_b);
                    w_e = (w_a == w_b);
                end
                default:   w_err = 1'b1;
            endcase
        end else begin
            case (w_cmd[3:0])
                L_AND:     w_res = {1'b0, w_a & w_b};
                L_NAND:    w_res = {1'b0, ~(w_a & w_b)};
                L_OR:      w_res = {1'b0, w_a | w_b};
                L_NOR:     w_res = {1'b0, ~(w_a | w_b)};
                L_XOR:     w_res = {1'b0, w_a ^ w_b};
                L_XNOR:    w_res = {1'b0, ~(w_a ^ w_b)};
                L_NOT_A:   w_res = {1'b0, ~w_a};
                L_NOT_B:   w_res = {1'b0, ~w_b};
                L_SHR1_A:  w_res = {1'b0, w_a >> 1};
                L_SHL1_A:  w_res = {w_a, 1'b0};
                L_SHR1_B:  w_res = {1'b0, w_b >> 1};
                L_SHL1_B:  w_res = {w_b, 1'b0};
                L_ROL_A_B: begin w_res = {1'b0, w_rol}; w_err = w_rot_hi; end
                L_ROR_A_B: begin w_res = {1'b0, w_ror}; w_err = w_rot_hi; end
                default:   w_err = 1'b1;
            endcase
        end
    end

    // Output registers: load only on a CE edge that completes an op (or times out).
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_res   <= '0;
            r_oflow <= 1'b0;
            r_cout  <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b0;
            r_err   <= 1'b0;
        end else if (CE && w_fire) begin
            r_res   <= w_res;
            r_oflow <= w_oflow;
            r_cout  <= w_cout;
            r_g     <= w_g;
            r_l     <= w_l;
            r_e     <= w_e;
            r_err   <= w_err;
        end
    end

    assign RES   = r_res;
    assign OFLOW = r_oflow;
    assign COUT  = r_cout;
    assign G     = r_g;
    assign L     = r_l;
    assign E     = r_e;
    assign ERR   = r_err;

endmodule

// File: tb/tb_modport_alu.sv
// Directed-vector bench for modport_alu; observed word is {RES, OFLOW, COUT, G, L, E, ERR}.
// Latency: each vector is applied, one rising edge passes, outputs are sampled 1 time unit later.
// Backpressure: CE-hold and, with ALU_TIMEOUT_EN, the late-operand / timeout window are exercised.
module tb_modport_alu;

    logic       clk;
    logic       RST;
    logic       CE;
    logic [7:0] OPA;
    logic [7:0] OPB;
    logic       Cin;
    logic       mode;
    logic [1:0] inp_valid;
    logic [3:0] CMD;
    logic [8:0] RES;
    logic       OFLOW;
    logic       COUT;
    logic       G;
    logic       L;
    logic       E;
    logic       ERR;

    logic [14:0] obs;
    int total = 0;
    int bad   = 0;

    assign obs = {RES, OFLOW, COUT, G, L, E, ERR};

    modport_alu #(.W(8), .N(4)) dut (
        .clk       (clk),
        .RST       (RST),
        .CE        (CE),
        .OPA       (OPA),
        .OPB       (OPB),
        .Cin       (Cin),
        .mode      (mode),
        .inp_valid (inp_valid),
        .CMD       (CMD),
        .RES       (RES),
        .OFLOW     (OFLOW),
        .COUT      (COUT),
        .G         (G),
        .L         (L),
        .E         (E),
        .ERR       (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector, let one rising edge pass, sample just after it.
    task automatic drive(input logic m, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [1:0] v);
        mode = m; CMD = c; OPA = a; OPB = b; Cin = ci; inp_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        total++;
        if (obs !== 15'h0) begin bad++; $display("FAIL reset_initial got=%h want=%h", obs, 15'h0); end
        RST = 1'b1;
        drive(1'b1, 4'd0, 8'h03, 8'h04, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h007, 6'b000000}) begin bad++; $display("FAIL pre_reset_add got=%h want=%h", obs, {9'h007, 6'b000000}); end
        #2 RST = 1'b0;
        #1;
        total++;
        if (obs !== 15'h0) begin bad++; $display("FAIL async_reset got=%h want=%h", obs, 15'h0); end
        RST = 1'b1;
        drive(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h100, 6'b010000}) begin bad++; $display("FAIL add_ff_01 got=%h want=%h", obs, {9'h100, 6'b010000}); end
    endtask

    task automatic test_arith;
        drive(1'b1, 4'd1, 8'h05, 8'h0A, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h1FB, 6'b100000}) begin bad++; $display("FAIL sub_borrow got=%h want=%h", obs, {9'h1FB, 6'b100000}); end
        drive(1'b1, 4'd8, 8'h22, 8'h22, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h000, 6'b000010}) begin bad++; $display("FAIL cmp_eq got=%h want=%h", obs, {9'h000, 6'b000010}); end
        drive(1'b1, 4'd2, 8'h10, 8'h20, 1'b1, 2'b11);
        total++;
        if (obs !== {9'h031, 6'b000000}) begin bad++; $display("FAIL add_cin got=%h want=%h", obs, {9'h031, 6'b000000}); end
        drive(1'b1, 4'd3, 8'h10, 8'h10, 1'b1, 2'b11);
        total++;
        if (obs !== {9'h1FF, 6'b100000}) begin bad++; $display("FAIL sub_cin got=%h want=%h", obs, {9'h1FF, 6'b100000}); end
        drive(1'b1, 4'd4, 8'hFF, 8'h00, 1'b0, 2'b01);
        total++;
        if (obs !== {9'h100, 6'b010000}) begin bad++; $display("FAIL inc_a got=%h want=%h", obs, {9'h100, 6'b010000}); end
        drive(1'b1, 4'd7, 8'h55, 8'h00, 1'b0, 2'b10);
        total++;
        if (obs !== {9'h1FF, 6'b100000}) begin bad++; $display("FAIL dec_b got=%h want=%h", obs, {9'h1FF, 6'b100000}); end
        drive(1'b1, 4'd8, 8'h10, 8'h20, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h000, 6'b000100}) begin bad++; $display("FAIL cmp_lt got=%h want=%h", obs, {9'h000, 6'b000100}); end
    endtask

    task automatic test_logic;
        drive(1'b0, 4'd4, 8'hF0, 8'h3C, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h0CC, 6'b000000}) begin bad++; $display("FAIL xor got=%h want=%h", obs, {9'h0CC, 6'b000000}); end
        drive(1'b0, 4'd12, 8'h81, 8'h01, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h003, 6'b000000}) begin bad++; $display("FAIL rol_1 got=%h want=%h", obs, {9'h003, 6'b000000}); end
        drive(1'b0, 4'd12, 8'h81, 8'h10, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h081, 6'b000001}) begin bad++; $display("FAIL rol_range got=%h want=%h", obs, {9'h081, 6'b000001}); end
        drive(1'b0, 4'd9, 8'h81, 8'h00, 1'b0, 2'b01);
        total++;
        if (obs !== {9'h102, 6'b000000}) begin bad++; $display("FAIL shl1_a got=%h want=%h", obs, {9'h102, 6'b000000}); end
        drive(1'b0, 4'd1, 8'hFF, 8'h0F, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h0F0, 6'b000000}) begin bad++; $display("FAIL nand got=%h want=%h", obs, {9'h0F0, 6'b000000}); end
        drive(1'b0, 4'd13, 8'h01, 8'h03, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h020, 6'b000000}) begin bad++; $display("FAIL ror_3 got=%h want=%h", obs, {9'h020, 6'b000000}); end
    endtask

    task automatic test_ce_hold;
        CE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 8'hA0 + 8'(i), 8'h0F, 1'b1, 2'b11);
            total++;
            if (obs !== {9'h020, 6'b000000}) begin bad++; $display("FAIL ce_hold_%0d got=%h want=%h", i, obs, {9'h020, 6'b000000}); end
        end
        CE = 1'b1;
    endtask

    task automatic test_errors;
        drive(1'b1, 4'd15, 8'h12, 8'h34, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h000, 6'b000001}) begin bad++; $display("FAIL illegal_arith got=%h want=%h", obs, {9'h000, 6'b000001}); end
        drive(1'b0, 4'd0, 8'hF0, 8'hF0, 1'b0, 2'b11);
        drive(1'b1, 4'd0, 8'h12, 8'h34, 1'b0, 2'b00);
        total++;
        if (obs !== {9'h000, 6'b000001}) begin bad++; $display("FAIL valid_00 got=%h want=%h", obs, {9'h000, 6'b000001}); end
        drive(1'b0, 4'd14, 8'h12, 8'h34, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h000, 6'b000001}) begin bad++; $display("FAIL illegal_logic got=%h want=%h", obs, {9'h000, 6'b000001}); end
        drive(1'b1, 4'd4, 8'h12, 8'h34, 1'b0, 2'b10);
        total++;
        if (obs !== {9'h000, 6'b000001}) begin bad++; $display("FAIL inc_a_missing got=%h want=%h", obs, {9'h000, 6'b000001}); end
    endtask

    task automatic test_late_operand;
        drive(1'b0, 4'd0, 8'hF0, 8'h3C, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h030, 6'b000000}) begin bad++; $display("FAIL and_base got=%h want=%h", obs, {9'h030, 6'b000000}); end
`ifdef ALU_TIMEOUT_EN
        drive(1'b1, 4'd0, 8'h30, 8'hAA, 1'b0, 2'b01);
        total++;
        if (obs !== {9'h030, 6'b000000}) begin bad++; $display("FAIL wait_hold got=%h want=%h", obs, {9'h030, 6'b000000}); end
        for (int i = 0; i < 4; i++) drive(1'b0, 4'd5, 8'h11, 8'h22, 1'b0, 2'b00);
        drive(1'b0, 4'd5, 8'h77, 8'h05, 1'b0, 2'b10);
        total++;
        if (obs !== {9'h035, 6'b000000}) begin bad++; $display("FAIL late_add got=%h want=%h", obs, {9'h035, 6'b000000}); end
        drive(1'b1, 4'd0, 8'h00, 8'h44, 1'b0, 2'b10);
        for (int i = 0; i < 15; i++) drive(1'b1, 4'd1, 8'h99, 8'h11, 1'b0, 2'b00);
        total++;
        if (obs !== {9'h035, 6'b000000}) begin bad++; $display("FAIL pre_timeout got=%h want=%h", obs, {9'h035, 6'b000000}); end
        drive(1'b1, 4'd1, 8'h99, 8'h11, 1'b0, 2'b00);
        total++;
        if (obs !== {9'h000, 6'b000001}) begin bad++; $display("FAIL timeout got=%h want=%h", obs, {9'h000, 6'b000001}); end
        drive(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h002, 6'b000000}) begin bad++; $display("FAIL after_timeout got=%h want=%h", obs, {9'h002, 6'b000000}); end
`else
        drive(1'b1, 4'd0, 8'h30, 8'hAA, 1'b0, 2'b01);
        total++;
        if (obs !== {9'h000, 6'b000001}) begin bad++; $display("FAIL partial_err got=%h want=%h", obs, {9'h000, 6'b000001}); end
        drive(1'b0, 4'd2, 8'h0F, 8'h30, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h03F, 6'b000000}) begin bad++; $display("FAIL after_partial got=%h want=%h", obs, {9'h03F, 6'b000000}); end
`endif
    endtask

    initial begin
        RST = 1'b0; CE = 1'b1; OPA = '0; OPB = '0; Cin = 1'b0;
        mode = 1'b0; inp_valid = 2'b00; CMD = '0;
        test_reset();
        test_arith();
        test_logic();
        test_ce_hold();
        test_errors();
        test_late_operand();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
